// File: rtl/musicbox_mode_arbiter.sv
// Music box mode arbiter: picks one live mode from the buttons, drains its
// SDRAM traffic before release, and produces the DAC sample.
module musicbox_mode_arbiter #(
    parameter int NUM_MODES     = 4,
    parameter int ADDR_W        = 25,
    parameter int DATA_W        = 16,
    parameter int AUDIO_W       = 8,
    parameter int MIX_ALL       = 0,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                            clock_50Mhz,
    input  logic                            reset_n,
    input  logic [NUM_MODES-1:0]            request_n,
    input  logic                            abort_n,
    input  logic [NUM_MODES-1:0]            mode_complete,
    input  logic [NUM_MODES*ADDR_W-1:0]     mode_addr,
    input  logic [NUM_MODES*DATA_W-1:0]     mode_wdata,
    input  logic [NUM_MODES-1:0]            mode_is_writing,
    input  logic [NUM_MODES-1:0]            mode_valid,
    input  logic [NUM_MODES*AUDIO_W-1:0]    mode_audio,
    input  logic                            sdram_isBusy,
    output logic [NUM_MODES-1:0]            active_onehot,
    output logic [$clog2(NUM_MODES+1)-1:0]  current_mode,
    output logic [1:0]                      fsm_state,
    output logic [ADDR_W-1:0]               sdram_inputAddress,
    output logic [DATA_W-1:0]               sdram_writeData,
    output logic                            sdram_isWriting,
    output logic                            sdram_inputValid,
    output logic [AUDIO_W-1:0]              audio_out,
    output logic                            done_pulse,
    output logic                            abort_pulse
);

    localparam int IDX_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1;
    localparam int CM_W  = $clog2(NUM_MODES + 1);
    localparam int CNT_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;
    localparam int SUM_W = AUDIO_W + $clog2(NUM_MODES);
    localparam logic [AUDIO_W-1:0] AUDIO_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DRAIN   = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t           state, stateNext;
    logic [IDX_W-1:0] idx, idxNext;
    logic             armed, armedNext;
    logic [CNT_W-1:0] drainCnt, drainCntNext;
    logic             abortCause, abortCauseNext;

    logic [ADDR_W-1:0]  addrArr  [NUM_MODES];
    logic [DATA_W-1:0]  wdataArr [NUM_MODES];
    logic [AUDIO_W-1:0] audioArr [NUM_MODES];

    for (genvar g = 0; g < NUM_MODES; g++) begin : gSlice
        assign addrArr[g]  = mode_addr[g*ADDR_W +: ADDR_W];
        assign wdataArr[g] = mode_wdata[g*DATA_W +: DATA_W];
        assign audioArr[g] = mode_audio[g*AUDIO_W +: AUDIO_W];
    end

    // Later iterations overwrite earlier ones, so the highest index wins.
    logic [IDX_W-1:0] reqIdx;
    always_comb begin
        reqIdx = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            if (!request_n[i]) begin
                reqIdx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            idx        <= '0;
            armed      <= 1'b1;
            drainCnt   <= '0;
            abortCause <= 1'b0;
        end else begin
            state      <= stateNext;
            idx        <= idxNext;
            armed      <= armedNext;
            drainCnt   <= drainCntNext;
            abortCause <= abortCauseNext;
        end
    end

    always_comb begin
        stateNext      = state;
        idxNext        = idx;
        armedNext      = armed;
        drainCntNext   = drainCnt;
        abortCauseNext = abortCause;
        unique case (state)
            IDLE: begin
                if (&request_n) begin
                    armedNext = 1'b1;
                end else if (armed) begin
                    stateNext = ACTIVE;
                    idxNext   = reqIdx;
                end
            end
            ACTIVE: begin
                if (!abort_n || mode_complete[idx]) begin
                    stateNext      = DRAIN;
                    abortCauseNext = !abort_n;
                    drainCntNext   = '0;
                end
            end
            DRAIN: begin
                if (!sdram_isBusy || drainCnt == CNT_LAST) begin
                    stateNext    = RELEASE;
                    armedNext    = 1'b0;
                    drainCntNext = '0;
                end else begin
                    drainCntNext = drainCnt + CNT_W'(1);
                end
            end
            RELEASE: begin
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    logic live;
    assign live = (state == ACTIVE) || (state == DRAIN);

    assign fsm_state     = state;
    assign current_mode  = live ? CM_W'(idx) + CM_W'(1) : '0;
    assign active_onehot = live ? NUM_MODES'(1) << idx : '0;
    assign done_pulse    = (state == RELEASE) && !abortCause;
    assign abort_pulse   = (state == RELEASE) && abortCause;

    // Address/data stay on the bus during DRAIN; only valid is withdrawn.
    assign sdram_inputAddress = live ? addrArr[idx] : '0;
    assign sdram_writeData    = live ? wdataArr[idx] : '0;
    assign sdram_isWriting    = live && mode_is_writing[idx];
    assign sdram_inputValid   = (state == ACTIVE) && mode_valid[idx];

    logic [SUM_W-1:0]   mixSum;
    logic [AUDIO_W-1:0] mixSat;
    logic [AUDIO_W-1:0] audioNext;

    always_comb begin
        mixSum = '0;
        for (int i = 0; i < NUM_MODES; i++) begin
            mixSum = mixSum + SUM_W'(audioArr[i]);
        end
        mixSat = (mixSum > SUM_W'(AUDIO_MAX)) ? AUDIO_MAX
                                              : mixSum[AUDIO_W-1:0];
        if (MIX_ALL != 0) begin
            audioNext = mixSat;
        end else begin
            audioNext = live ? audioArr[idx] : '0;
        end
    end

    always_ff @(posedge clock_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            audio_out <= '0;
        end else begin
            audio_out <= audioNext;
        end
    end

endmodule

// File: tb/tb_musicbox_mode_arbiter.sv
// Directed bench for musicbox_mode_arbiter: one DUT per audio mode,
// both driven by the same stimulus.
module tb_musicbox_mode_arbiter;

    logic         clock_50Mhz = 1'b0;
    logic         reset_n;
    logic [3:0]   request_n;
    logic         abort_n;
    logic [3:0]   mode_complete;
    logic [99:0]  mode_addr;
    logic [63:0]  mode_wdata;
    logic [3:0]   mode_is_writing;
    logic [3:0]   mode_valid;
    logic [31:0]  mode_audio;
    logic         sdram_isBusy;

    logic [3:0]   active_onehot, m_active_onehot;
    logic [2:0]   current_mode, m_current_mode;
    logic [1:0]   fsm_state, m_fsm_state;
    logic [24:0]  sdram_inputAddress, m_sdram_inputAddress;
    logic [15:0]  sdram_writeData, m_sdram_writeData;
    logic         sdram_isWriting, m_sdram_isWriting;
    logic         sdram_inputValid, m_sdram_inputValid;
    logic [7:0]   audio_out, m_audio_out;
    logic         done_pulse, m_done_pulse;
    logic         abort_pulse, m_abort_pulse;

    int checks = 0;
    int errors = 0;

    always #10 clock_50Mhz = ~clock_50Mhz;

    musicbox_mode_arbiter #(.MIX_ALL(0), .DRAIN_TIMEOUT(16)) dut (
        .clock_50Mhz(clock_50Mhz), .reset_n(reset_n),
        .request_n(request_n), .abort_n(abort_n),
        .mode_complete(mode_complete), .mode_addr(mode_addr),
        .mode_wdata(mode_wdata), .mode_is_writing(mode_is_writing),
        .mode_valid(mode_valid), .mode_audio(mode_audio),
        .sdram_isBusy(sdram_isBusy), .active_onehot(active_onehot),
        .current_mode(current_mode), .fsm_state(fsm_state),
        .sdram_inputAddress(sdram_inputAddress),
        .sdram_writeData(sdram_writeData),
        .sdram_isWriting(sdram_isWriting),
        .sdram_inputValid(sdram_inputValid), .audio_out(audio_out),
        .done_pulse(done_pulse), .abort_pulse(abort_pulse)
    );

    musicbox_mode_arbiter #(.MIX_ALL(1), .DRAIN_TIMEOUT(16)) dutMix (
        .clock_50Mhz(clock_50Mhz), .reset_n(reset_n),
        .request_n(request_n), .abort_n(abort_n),
        .mode_complete(mode_complete), .mode_addr(mode_addr),
        .mode_wdata(mode_wdata), .mode_is_writing(mode_is_writing),
        .mode_valid(mode_valid), .mode_audio(mode_audio),
        .sdram_isBusy(sdram_isBusy), .active_onehot(m_active_onehot),
        .current_mode(m_current_mode), .fsm_state(m_fsm_state),
        .sdram_inputAddress(m_sdram_inputAddress),
        .sdram_writeData(m_sdram_writeData),
        .sdram_isWriting(m_sdram_isWriting),
        .sdram_inputValid(m_sdram_inputValid), .audio_out(m_audio_out),
        .done_pulse(m_done_pulse), .abort_pulse(m_abort_pulse)
    );

    task automatic step();
        @(posedge clock_50Mhz);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        step();
        step();
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", fsm_state); end
        checks++; if (current_mode !== 3'd0) begin errors++; $display("FAIL reset_mode: got %0d want 0", current_mode); end
        checks++; if (active_onehot !== 4'b0000) begin errors++; $display("FAIL reset_onehot: got %b want 0000", active_onehot); end
        checks++; if (sdram_inputAddress !== 25'd0 || sdram_inputValid !== 1'b0) begin errors++; $display("FAIL reset_sdram: addr %0h valid %b want 0", sdram_inputAddress, sdram_inputValid); end
        checks++; if (audio_out !== 8'd0 || done_pulse !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL reset_misc: audio %0h done %b abort %b want 0", audio_out, done_pulse, abort_pulse); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_select_low();
        request_n = 4'b1110;
        step();
        checks++; if (fsm_state !== 2'd1 || current_mode !== 3'd1 || active_onehot !== 4'b0001) begin errors++; $display("FAIL sel0_enter: state %0d mode %0d oh %b want 1 1 0001", fsm_state, current_mode, active_onehot); end
        repeat (9) step();
        checks++; if (fsm_state !== 2'd1 || current_mode !== 3'd1) begin errors++; $display("FAIL sel0_hold: state %0d mode %0d want 1 1", fsm_state, current_mode); end
        mode_complete = 4'b0001;
        step();
        checks++; if (fsm_state !== 2'd2 || active_onehot !== 4'b0001) begin errors++; $display("FAIL sel0_drain: state %0d oh %b want 2 0001", fsm_state, active_onehot); end
        mode_complete = 4'b0000;
        step();
        checks++; if (fsm_state !== 2'd3 || done_pulse !== 1'b1 || abort_pulse !== 1'b0) begin errors++; $display("FAIL sel0_release: state %0d done %b abort %b want 3 1 0", fsm_state, done_pulse, abort_pulse); end
        checks++; if (current_mode !== 3'd0 || active_onehot !== 4'b0000) begin errors++; $display("FAIL sel0_rel_mode: mode %0d oh %b want 0 0000", current_mode, active_onehot); end
        step();
        checks++; if (fsm_state !== 2'd0 || done_pulse !== 1'b0) begin errors++; $display("FAIL sel0_idle: state %0d done %b want 0 0", fsm_state, done_pulse); end
        repeat (3) step();
        checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL sel0_no_retrigger: state %0d want 0", fsm_state); end
        request_n = 4'b1111;
        step();
        request_n = 4'b1110;
        step();
        checks++; if (fsm_state !== 2'd1 || current_mode !== 3'd1) begin errors++; $display("FAIL sel0_rearm: state %0d mode %0d want 1 1", fsm_state, current_mode); end
        request_n = 4'b1111;
        mode_complete = 4'b0001;
        step();
        mode_complete = 4'b0000;
        step();
        checks++; if (done_pulse !== 1'b1) begin errors++; $display("FAIL sel0_done2: done %b want 1", done_pulse); end
        step();
        step();
    endtask

    task automatic test_priority();
        request_n = 4'b0110;
        step();
        checks++; if (current_mode !== 3'd4 || active_onehot !== 4'b1000) begin errors++; $display("FAIL prio_enter: mode %0d oh %b want 4 1000", current_mode, active_onehot); end
        request_n = 4'b1101;
        step();
        checks++; if (fsm_state !== 2'd1 || current_mode !== 3'd4) begin errors++; $display("FAIL prio_no_preempt: state %0d mode %0d want 1 4", fsm_state, current_mode); end
        mode_complete = 4'b0010;
        step();
        checks++; if (fsm_state !== 2'd1) begin errors++; $display("FAIL prio_foreign_complete: state %0d want 1", fsm_state); end
        mode_complete = 4'b0000;
        abort_n = 1'b0;
        step();
        checks++; if (fsm_state !== 2'd2) begin errors++; $display("FAIL prio_abort_drain: state %0d want 2", fsm_state); end
        abort_n = 1'b1;
        request_n = 4'b1111;
        step();
        checks++; if (abort_pulse !== 1'b1 || done_pulse !== 1'b0) begin errors++; $display("FAIL prio_abort_pulse: abort %b done %b want 1 0", abort_pulse, done_pulse); end
        step();
        step();
    endtask

    task automatic test_mux();
        mode_addr[50 +: 25] = 25'h1ABCDE;
        mode_wdata[32 +: 16] = 16'hBEEF;
        mode_is_writing = 4'b0100;
        mode_valid = 4'b0111;
        checks++; if (sdram_inputAddress !== 25'd0 || sdram_inputValid !== 1'b0) begin errors++; $display("FAIL mux_idle: addr %0h valid %b want 0 0", sdram_inputAddress, sdram_inputValid); end
        request_n = 4'b1011;
        step();
        request_n = 4'b1111;
        checks++; if (current_mode !== 3'd3 || sdram_inputAddress !== 25'h1ABCDE) begin errors++; $display("FAIL mux_addr: mode %0d addr %0h want 3 1abcde", current_mode, sdram_inputAddress); end
        checks++; if (sdram_writeData !== 16'hBEEF || sdram_isWriting !== 1'b1 || sdram_inputValid !== 1'b1) begin errors++; $display("FAIL mux_data: wd %0h wr %b v %b want beef 1 1", sdram_writeData, sdram_isWriting, sdram_inputValid); end
        abort_n = 1'b0;
        mode_complete = 4'b0100;
        step();
        checks++; if (fsm_state !== 2'd2 || sdram_inputValid !== 1'b0) begin errors++; $display("FAIL mux_drain_valid: state %0d valid %b want 2 0", fsm_state, sdram_inputValid); end
        checks++; if (sdram_inputAddress !== 25'h1ABCDE || sdram_isWriting !== 1'b1) begin errors++; $display("FAIL mux_drain_hold: addr %0h wr %b want 1abcde 1", sdram_inputAddress, sdram_isWriting); end
        abort_n = 1'b1;
        mode_complete = 4'b0000;
        step();
        checks++; if (abort_pulse !== 1'b1 || done_pulse !== 1'b0) begin errors++; $display("FAIL mux_both_abort: abort %b done %b want 1 0", abort_pulse, done_pulse); end
        checks++; if (sdram_inputAddress !== 25'd0 || sdram_writeData !== 16'd0 || sdram_isWriting !== 1'b0) begin errors++; $display("FAIL mux_release: addr %0h wd %0h wr %b want 0", sdram_inputAddress, sdram_writeData, sdram_isWriting); end
        step();
        step();
        mode_valid = 4'b0000;
        mode_is_writing = 4'b0000;
    endtask

    task automatic test_drain_timeout();
        int cnt;
        sdram_isBusy = 1'b1;
        request_n = 4'b1110;
        step();
        request_n = 4'b1111;
        mode_complete = 4'b0001;
        step();
        mode_complete = 4'b0000;
        cnt = 0;
        while (fsm_state == 2'd2 && cnt < 100) begin
            cnt++;
            step();
        end
        checks++; if (cnt !== 16 || fsm_state !== 2'd3 || done_pulse !== 1'b1) begin errors++; $display("FAIL drain_timeout: cycles %0d state %0d done %b want 16 3 1", cnt, fsm_state, done_pulse); end
        step();
        step();
        request_n = 4'b1110;
        step();
        request_n = 4'b1111;
        mode_complete = 4'b0001;
        step();
        mode_complete = 4'b0000;
        cnt = 0;
        while (fsm_state == 2'd2 && cnt < 100) begin
            cnt++;
            if (cnt == 4) sdram_isBusy = 1'b0;
            step();
        end
        checks++; if (cnt !== 4 || fsm_state !== 2'd3) begin errors++; $display("FAIL drain_busy_drop: cycles %0d state %0d want 4 3", cnt, fsm_state); end
        sdram_isBusy = 1'b0;
        step();
        step();
    endtask

    task automatic test_audio();
        mode_audio = {8'd0, 8'd0, 8'h5A, 8'd0};
        step();
        checks++; if (audio_out !== 8'd0 || m_audio_out !== 8'h5A) begin errors++; $display("FAIL audio_idle: sel %0h mix %0h want 0 5a", audio_out, m_audio_out); end
        request_n = 4'b1101;
        step();
        checks++; if (fsm_state !== 2'd1 || audio_out !== 8'd0) begin errors++; $display("FAIL audio_latency: state %0d audio %0h want 1 0", fsm_state, audio_out); end
        step();
        checks++; if (audio_out !== 8'h5A) begin errors++; $display("FAIL audio_sel: got %0h want 5a", audio_out); end
        mode_audio = {8'd0, 8'd0, 8'd100, 8'd200};
        step();
        checks++; if (audio_out !== 8'd100 || m_audio_out !== 8'd255) begin errors++; $display("FAIL audio_sat: sel %0d mix %0d want 100 255", audio_out, m_audio_out); end
        mode_audio = {8'd40, 8'd30, 8'd20, 8'd10};
        step();
        checks++; if (audio_out !== 8'd20 || m_audio_out !== 8'd100) begin errors++; $display("FAIL audio_sum: sel %0d mix %0d want 20 100", audio_out, m_audio_out); end
        mode_audio = {8'd255, 8'd255, 8'd255, 8'd255};
        step();
        checks++; if (m_audio_out !== 8'd255) begin errors++; $display("FAIL audio_max: mix %0d want 255", m_audio_out); end
    endtask

    task automatic test_reset_mid();
        mode_valid = 4'b0010;
        #3;
        checks++; if (sdram_inputAddress !== 25'h00000A2 || sdram_inputValid !== 1'b1) begin errors++; $display("FAIL rst_pre: addr %0h valid %b want a2 1", sdram_inputAddress, sdram_inputValid); end
        reset_n = 1'b0;
        #2;
        checks++; if (fsm_state !== 2'd0 || current_mode !== 3'd0 || active_onehot !== 4'b0000) begin errors++; $display("FAIL rst_async_state: state %0d mode %0d oh %b want 0", fsm_state, current_mode, active_onehot); end
        checks++; if (sdram_inputAddress !== 25'd0 || sdram_inputValid !== 1'b0 || audio_out !== 8'd0 || m_audio_out !== 8'd0) begin errors++; $display("FAIL rst_async_out: addr %0h v %b a %0h m %0h want 0", sdram_inputAddress, sdram_inputValid, audio_out, m_audio_out); end
        checks++; if (done_pulse !== 1'b0 || abort_pulse !== 1'b0) begin errors++; $display("FAIL rst_no_pulse: done %b abort %b want 0 0", done_pulse, abort_pulse); end
        #3;
        reset_n = 1'b1;
        step();
        checks++; if (fsm_state !== 2'd1 || current_mode !== 3'd2) begin errors++; $display("FAIL rst_rearm: state %0d mode %0d want 1 2", fsm_state, current_mode); end
    endtask

    initial begin
        reset_n = 1'b0;
        request_n = 4'b1111;
        abort_n = 1'b1;
        mode_complete = 4'b0000;
        mode_addr = {25'h00000A4, 25'h00000A3, 25'h00000A2, 25'h00000A1};
        mode_wdata = {16'h4444, 16'h3333, 16'h2222, 16'h1111};
        mode_is_writing = 4'b0000;
        mode_valid = 4'b0000;
        mode_audio = 32'd0;
        sdram_isBusy = 1'b0;
        test_reset();
        test_select_low();
        test_priority();
        test_mux();
        test_drain_timeout();
        test_audio();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
